// File: rtl/irq_trap_ctrl_pkg.sv
// Shared encodings for the interrupt/trap controller and the microcode decoder it feeds.
// Also provides the cause-to-vector helper.
package irq_trap_ctrl_pkg;
  localparam logic [3:0] DS_IRQ    = 4'd0;
  localparam logic [3:0] DS_FETCH  = 4'd1;
  localparam logic [3:0] DS_DECODE = 4'd2;
  localparam logic [3:0] DS_ADDR   = 4'd3;
  localparam logic [3:0] DS_READ   = 4'd4;
  localparam logic [3:0] DS_EXEC   = 4'd5;
  localparam logic [3:0] DS_WRITE  = 4'd6;
  localparam logic [3:0] DS_BRANCH = 4'd7;
  localparam logic [3:0] DS_EXECM  = 4'd8;

  localparam int CAUSE_W = 4;

  localparam logic [2:0] TRAP_ILLEGAL = 3'd0;
  localparam logic [2:0] TRAP_BUSERR  = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ_I,
    ST_REQ_T,
    ST_SERVICE
  } fsm_t;

  function automatic logic [15:0] calc_vector(input logic [15:0] base,
                                              input logic [15:0] stride,
                                              input logic [CAUSE_W-1:0] c);
    return base + 16'(c) * stride;
  endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous IRQ line plus a one-cycle rising-edge pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic a,
  output logic pulse
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= a;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;
endmodule

// File: rtl/irq_trap_ctrl.sv
// Interrupt/trap controller: pending/mask/enable, lowest-index priority, trap arbitration,
// and the request/acknowledge handshake against the decoder state.
module irq_trap_ctrl
  import irq_trap_ctrl_pkg::*;
#(
  parameter int          NIRQ       = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0008,
  parameter int          VEC_STRIDE = 4,
  parameter logic [3:0]  IRQ_STATE  = DS_IRQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NIRQ-1:0]    irq_in,
  input  logic               trap_req,
  input  logic [2:0]         trap_code,
  input  logic [3:0]         dec_state,
  input  logic               ie_set,
  input  logic               ie_clr,
  input  logic               reti,
  input  logic               mask_we,
  input  logic [NIRQ-1:0]    mask_wdata,
  output logic               irq_r,
  output logic               trap_r,
  output logic [CAUSE_W-1:0] cause,
  output logic [15:0]        vector,
  output logic               ie,
  output logic               in_handler,
  output logic               dbl_fault
);
  fsm_t            state, state_nx;
  logic [NIRQ-1:0] edge_p, pending, mask, eligible, ack_clr;
  logic [2:0]      win;
  logic            any, ack;

  irq_sync_edge u_sync [NIRQ-1:0] (
    .clk   (clk),
    .reset (reset),
    .a     (irq_in),
    .pulse (edge_p)
  );

  assign eligible = pending & mask;
  assign any      = |eligible;
  assign ack      = (state == ST_REQ_I) && (dec_state == IRQ_STATE);

  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    win = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (eligible[i]) win = 3'(i);
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NIRQ; i++)
      ack_clr[i] = ack && (cause[2:0] == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (trap_req) state_nx = ST_REQ_T;
                  else if (ie && any) state_nx = ST_REQ_I;
      ST_REQ_I:   if (dec_state == IRQ_STATE) state_nx = ST_SERVICE;
      ST_REQ_T:   state_nx = ST_SERVICE;
      ST_SERVICE: if (reti) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Request/handler flags decode straight from the state register, so they stay registered.
  always_comb begin
    irq_r      = (state == ST_REQ_I);
    trap_r     = (state == ST_REQ_T);
    in_handler = (state == ST_SERVICE);
    vector     = (state == ST_IDLE) ? 16'h0000
                                    : calc_vector(VEC_BASE, 16'(VEC_STRIDE), cause);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      mask      <= '1;
      ie        <= 1'b0;
      cause     <= '0;
      dbl_fault <= 1'b0;
    end else begin
      // A fresh edge on the line being acknowledged survives the clear.
      pending <= (pending & ~ack_clr) | edge_p;
      if (mask_we) mask <= mask_wdata;
      if (ack || ie_clr) ie <= 1'b0;
      else if (ie_set)   ie <= 1'b1;
      if (state == ST_IDLE) begin
        if (trap_req)         cause <= {1'b1, trap_code};
        else if (ie && any)   cause <= {1'b0, win};
      end
      if (trap_req && state == ST_SERVICE) dbl_fault <= 1'b1;
    end
  end
endmodule
